// File: rtl/gain_pkg.sv
// Shared types, register addresses and helpers for the gain ramp controller.
package gain_pkg;

    typedef enum logic [1:0] {IDLE, UP, DOWN} rampState_t;

    localparam logic [1:0] ADDR_TARGET = 2'd0;
    localparam logic [1:0] ADDR_STEP   = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    // Unity gain in ufi(wdt, wdt/2)
    function automatic int unsigned coefUnity(input int unsigned wdt);
        return 32'(1) << (wdt / 2);
    endfunction

endpackage

// File: rtl/gain_ramp_ctrl_if.sv
// Avalon-MM register port of the gain ramp controller.
interface gain_ramp_ctrl_if;

    localparam int unsigned ADDR_WDT = 2;
    localparam int unsigned DATA_WDT = 32;

    logic [ADDR_WDT-1:0] avsAddr;
    logic                avsWr;
    logic [DATA_WDT-1:0] avsWrData;
    logic [DATA_WDT-1:0] avsRdData;

    modport master (output avsAddr, output avsWr, output avsWrData, input avsRdData);
    modport slave  (input avsAddr, input avsWr, input avsWrData, output avsRdData);

endinterface

// File: rtl/gain_ramp_step.sv
// One ramp step toward target with clipping; never overshoots or wraps.
module gain_ramp_step #(
    parameter int unsigned COEF_WDT = 16
) (
    input  logic [COEF_WDT-1:0] coef,
    input  logic [COEF_WDT-1:0] step,
    input  logic [COEF_WDT-1:0] target,
    input  logic                dir,
    output logic [COEF_WDT-1:0] coef_next_c,
    output logic                reached_c
);

    logic [COEF_WDT:0] sum;
    logic [COEF_WDT:0] diff;
    logic              up_reached;
    logic              down_reached;

    // One extra bit keeps carry/borrow visible, so the clip sees true magnitudes
    assign sum          = {1'b0, coef} + {1'b0, step};
    assign diff         = {1'b0, coef} - {1'b0, step};
    assign up_reached   = (sum >= {1'b0, target});
    assign down_reached = ($signed(diff) <= $signed({1'b0, target}));

    always_comb begin
        reached_c   = dir ? up_reached : down_reached;
        coef_next_c = dir ? sum[COEF_WDT-1:0] : diff[COEF_WDT-1:0];
        if (reached_c) begin
            coef_next_c = target;
        end
    end

endmodule

// File: rtl/gain_ramp_ctrl.sv
// Click-free gain coefficient sequencer: ramps coef toward a CPU-written target per sample.
// Optional feature macro: GAIN_RAMP_IRQ_EN (adds irq port and CTRL.IRQ_MASK).
module gain_ramp_ctrl
    import gain_pkg::*;
#(
    parameter int unsigned          COEF_WDT = 16,
    parameter logic [COEF_WDT-1:0]  COEF_RST = COEF_WDT'(coefUnity(COEF_WDT))
) (
    input  logic                clk,
    input  logic                reset,
    gain_ramp_ctrl_if.slave     avs,
    input  logic                st,
    output logic [COEF_WDT-1:0] coef,
    output logic                busy
`ifdef GAIN_RAMP_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_UP   = 2'(UP);
    localparam logic [1:0] ST_DOWN = 2'(DOWN);

    logic [1:0]          state, state_nxt;
    logic [COEF_WDT-1:0] coef_nxt;
    logic [COEF_WDT-1:0] target, target_nxt;
    logic [COEF_WDT-1:0] step, step_nxt;
    logic                freeze, freeze_nxt;
    logic                done, done_nxt;
    logic                done_set;
    logic [COEF_WDT-1:0] wr_coef;
    logic                wr_target, wr_step, wr_ctrl, wr_status;
    logic [COEF_WDT-1:0] step_coef_c;
    logic                step_reached_c;
    logic                unused_wrdata;
`ifdef GAIN_RAMP_IRQ_EN
    logic                mask, mask_nxt;
`endif

    assign wr_coef       = avs.avsWrData[COEF_WDT-1:0];
    assign wr_target     = avs.avsWr && (avs.avsAddr == ADDR_TARGET);
    assign wr_step       = avs.avsWr && (avs.avsAddr == ADDR_STEP);
    assign wr_ctrl       = avs.avsWr && (avs.avsAddr == ADDR_CTRL);
    assign wr_status     = avs.avsWr && (avs.avsAddr == ADDR_STATUS);
    assign unused_wrdata = ^avs.avsWrData;

    gain_ramp_step #(.COEF_WDT(COEF_WDT)) u_step (
        .coef        (coef),
        .step        (step),
        .target      (target),
        .dir         (state == ST_UP),
        .coef_next_c (step_coef_c),
        .reached_c   (step_reached_c)
    );

    // Next-state: a TARGET write pre-empts any sample step in the same cycle
    always_comb begin
        state_nxt  = state;
        coef_nxt   = coef;
        target_nxt = target;
        step_nxt   = step;
        freeze_nxt = freeze;
        done_set   = 1'b0;
`ifdef GAIN_RAMP_IRQ_EN
        mask_nxt   = mask;
`endif
        if (wr_target) begin
            target_nxt = wr_coef;
            if (step == '0) begin
                coef_nxt  = wr_coef;
                state_nxt = ST_IDLE;
                done_set  = 1'b1;
            end else if (wr_coef > coef) begin
                state_nxt = ST_UP;
            end else if (wr_coef < coef) begin
                state_nxt = ST_DOWN;
            end else begin
                state_nxt = ST_IDLE;
                done_set  = 1'b1;
            end
        end else if (st && !freeze && (state != ST_IDLE)) begin
            coef_nxt = step_coef_c;
            if (step_reached_c) begin
                state_nxt = ST_IDLE;
                done_set  = 1'b1;
            end
        end
        if (wr_step) begin
            step_nxt = wr_coef;
        end
        if (wr_ctrl) begin
            freeze_nxt = avs.avsWrData[0];
`ifdef GAIN_RAMP_IRQ_EN
            mask_nxt   = avs.avsWrData[1];
`endif
        end
        done_nxt = (done & ~(wr_status & avs.avsWrData[1])) | done_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            coef   <= COEF_RST;
            target <= COEF_RST;
            step   <= '0;
            freeze <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef GAIN_RAMP_IRQ_EN
            mask   <= 1'b0;
            irq    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            coef   <= coef_nxt;
            target <= target_nxt;
            step   <= step_nxt;
            freeze <= freeze_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != ST_IDLE);
`ifdef GAIN_RAMP_IRQ_EN
            mask   <= mask_nxt;
            irq    <= done_nxt & mask_nxt;
`endif
        end
    end

    always_comb begin
        avs.avsRdData = '0;
        case (avs.avsAddr)
            ADDR_TARGET: avs.avsRdData = 32'(target);
            ADDR_STEP:   avs.avsRdData = 32'(step);
`ifdef GAIN_RAMP_IRQ_EN
            ADDR_CTRL:   avs.avsRdData = 32'({mask, freeze});
`else
            ADDR_CTRL:   avs.avsRdData = 32'(freeze);
`endif
            ADDR_STATUS: avs.avsRdData = 32'({done, busy});
            default:     avs.avsRdData = '0;
        endcase
    end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed and randomized check of gain_ramp_ctrl against a behavioural register/ramp model.
// Builds with or without GAIN_RAMP_IRQ_EN.
module tb_gain_ramp_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st = 1'b0;
    logic [15:0] coef;
    logic        busy;
`ifdef GAIN_RAMP_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int m_coef, m_tgt, m_step;
    bit m_freeze, m_mask, m_done, m_ramp, m_up;

    gain_ramp_ctrl_if bus ();

    gain_ramp_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .avs   (bus.slave),
        .st    (st),
        .coef  (coef),
        .busy  (busy)
`ifdef GAIN_RAMP_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_tgt);
            2'd1:    return 32'(m_step);
`ifdef GAIN_RAMP_IRQ_EN
            2'd2:    return {30'd0, m_mask, m_freeze};
`else
            2'd2:    return {31'd0, m_freeze};
`endif
            default: return {30'd0, m_done, m_ramp};
        endcase
    endfunction

    task automatic model_reset();
        m_coef = 32'h100; m_tgt = 32'h100; m_step = 0;
        m_freeze = 0; m_mask = 0; m_done = 0; m_ramp = 0; m_up = 0;
    endtask

    // Applies one clock of bus/strobe activity to the model
    task automatic model_step(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic s);
        int  t, n;
        bit  set_done, clr_done;
        t = int'(d[15:0]);
        set_done = 0;
        clr_done = wr && (a == 2'd3) && d[1];
        if (wr && a == 2'd0) begin
            m_tgt = t;
            if (m_step == 0) begin
                m_coef = t; m_ramp = 0; set_done = 1;
            end else if (t == m_coef) begin
                m_ramp = 0; set_done = 1;
            end else begin
                m_ramp = 1; m_up = (t > m_coef);
            end
        end else if (s && !m_freeze && m_ramp) begin
            n = m_up ? m_coef + m_step : m_coef - m_step;
            if ((m_up && n >= m_tgt) || (!m_up && n <= m_tgt)) begin
                m_coef = m_tgt; m_ramp = 0; set_done = 1;
            end else begin
                m_coef = n;
            end
        end
        if (wr && a == 2'd1) m_step = t;
        if (wr && a == 2'd2) begin
            m_freeze = d[0];
`ifdef GAIN_RAMP_IRQ_EN
            m_mask = d[1];
`endif
        end
        m_done = (m_done && !clr_done) || set_done;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_coef"}, 32'(coef), 32'(m_coef));
        check({tag, "_busy"}, 32'(busy), 32'(m_ramp));
        check({tag, "_rd"}, bus.avsRdData, model_rd(bus.avsAddr));
`ifdef GAIN_RAMP_IRQ_EN
        check({tag, "_irq"}, 32'(irq), 32'(m_done && m_mask));
`endif
    endtask

    task automatic cycle(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic s);
        @(negedge clk);
        bus.avsWr = wr; bus.avsAddr = a; bus.avsWrData = d; st = s;
        model_step(wr, a, d, s);
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.avsWr = 1'b0; st = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.avsAddr = 2'd0; bus.avsWr = 1'b0; bus.avsWrData = '0;
        model_reset();

        // 1: reset values of every register
        do_reset();
        for (int a = 0; a < 4; a++) cycle(1'b0, 2'(a), 32'd0, 1'b0);
        check("t1_coef", 32'(coef), 32'h100);

        // 2: ramp up in 0x40 steps, st spaced 3 clk
        cycle(1'b1, 2'd1, 32'h40, 1'b0);
        cycle(1'b1, 2'd0, 32'h200, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 2'd3, 32'd0, 1'b1);
            check("t2_coef", 32'(coef), 32'h100 + 32'h40 * 32'(k + 1));
            cycle(1'b0, 2'd3, 32'd0, 1'b0);
            cycle(1'b0, 2'd3, 32'd0, 1'b0);
        end
        check("t2_status", bus.avsRdData, 32'h2);

        // 3: ramp down with clip at target
        cycle(1'b1, 2'd1, 32'h0, 1'b0);
        cycle(1'b1, 2'd0, 32'h100, 1'b0);
        cycle(1'b1, 2'd3, 32'h2, 1'b0);
        cycle(1'b1, 2'd1, 32'h70, 1'b0);
        cycle(1'b1, 2'd0, 32'h20, 1'b0);
        cycle(1'b0, 2'd3, 32'd0, 1'b1);
        check("t3_first", 32'(coef), 32'h90);
        cycle(1'b0, 2'd3, 32'd0, 1'b1);
        check("t3_clip", 32'(coef), 32'h20);
        check("t3_status", bus.avsRdData, 32'h2);

        // 4: huge step saturates at target without wrap
        cycle(1'b1, 2'd1, 32'h0, 1'b0);
        cycle(1'b1, 2'd0, 32'h100, 1'b0);
        cycle(1'b1, 2'd1, 32'hFFFF, 1'b0);
        cycle(1'b1, 2'd0, 32'hFFFF, 1'b0);
        cycle(1'b0, 2'd3, 32'd0, 1'b1);
        check("t4_nowrap", 32'(coef), 32'hFFFF);

        // 5: retarget on a strobe cycle, then freeze
        cycle(1'b1, 2'd1, 32'h0, 1'b0);
        cycle(1'b1, 2'd0, 32'h100, 1'b0);
        cycle(1'b1, 2'd1, 32'h10, 1'b0);
        cycle(1'b1, 2'd0, 32'h200, 1'b0);
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
        cycle(1'b0, 2'd0, 32'd0, 1'b1);
        check("t5_ramp", 32'(coef), 32'h120);
        cycle(1'b1, 2'd0, 32'h180, 1'b1);
        check("t5_wr_wins", 32'(coef), 32'h120);
        cycle(1'b1, 2'd2, 32'h1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 2'd2, 32'd0, 1'b1);
        check("t5_frozen", 32'(coef), 32'h120);
        check("t5_busy", 32'(busy), 32'h1);
        cycle(1'b1, 2'd2, 32'h0, 1'b0);
        cycle(1'b0, 2'd3, 32'd0, 1'b1);
        check("t5_resume", 32'(coef), 32'h130);

        // 6: reset mid-ramp, then irq / done W1C
        do_reset();
        check("t6_coef", 32'(coef), 32'h100);
        check("t6_busy", 32'(busy), 32'h0);
        cycle(1'b0, 2'd3, 32'd0, 1'b0);
        check("t6_status", bus.avsRdData, 32'h0);
        cycle(1'b1, 2'd2, 32'h2, 1'b0);
        cycle(1'b1, 2'd0, 32'h300, 1'b0);
        check("t6_jump", 32'(coef), 32'h300);
`ifdef GAIN_RAMP_IRQ_EN
        check("t6_irq_set", 32'(irq), 32'h1);
`endif
        cycle(1'b1, 2'd3, 32'h2, 1'b0);
        check("t6_done_clr", bus.avsRdData, 32'h0);
`ifdef GAIN_RAMP_IRQ_EN
        check("t6_irq_clr", 32'(irq), 32'h0);
`endif

        // Randomized traffic against the model
        cycle(1'b1, 2'd2, 32'h0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            logic        wr, s;
            logic [1:0]  a;
            logic [31:0] d;
            wr = ($urandom_range(0, 99) < 30);
            a  = 2'($urandom_range(0, 3));
            d  = $urandom();
            if (a == 2'd1 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_01FF;
            if (a == 2'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
            s  = 1'($urandom_range(0, 1));
            cycle(wr, a, d, s);
            if (i == 300) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
